// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared widths, default depth and copy-engine state encoding
package onchip_mem_pkg;
    localparam int ADDR_W        = 13;
    localparam int DATA_W        = 32;
    localparam int BE_W          = 4;
    localparam int DEPTH_DEFAULT = 5120;
    typedef enum logic [2:0] {IDLE, CHECK, RD, RD_WAIT, WR, FIN} state_t;
endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// onchip_mem_rd_pipe: delays the read-accept pulse by LATENCY cycles to strobe read-data capture
module onchip_mem_rd_pipe #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic accept,
    output logic strobe
);
    logic [LATENCY-1:0] valid_sr;
    // shift the accept pulse along; the top bit marks the cycle m_readdata is valid
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) valid_sr <= '0;
        else valid_sr <= LATENCY'({valid_sr, accept});
    assign strobe = valid_sr[LATENCY-1];
endmodule

// File: rtl/onchip_mem_copy_master.sv
// onchip_mem_copy_master: Avalon-MM word-copy engine; define COPY_CHECKSUM_EN to add the write checksum port
module onchip_mem_copy_master
    import onchip_mem_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_read,
    output logic              m_write,
    output logic [BE_W-1:0]   m_byteenable,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    state_t            state;
    logic [ADDR_W-1:0] cur_src, cur_dst, remaining;
    logic [ADDR_W:0]   src_end, dst_end;
    logic              bad_req, rd_accept, rd_strobe;

    assign src_end      = {1'b0, cur_src} + {1'b0, remaining};
    assign dst_end      = {1'b0, cur_dst} + {1'b0, remaining};
    assign bad_req      = src_end > (ADDR_W+1)'(DEPTH) || dst_end > (ADDR_W+1)'(DEPTH) ||
                          (cur_dst > cur_src && {1'b0, cur_dst} < src_end);
    assign rd_accept    = state == RD && m_read && !m_waitrequest;
    assign m_chipselect = m_read | m_write;

    onchip_mem_rd_pipe #(.LATENCY(READ_LATENCY)) u_rd_pipe (
        .clk    (clk),
        .reset_n(reset_n),
        .accept (rd_accept),
        .strobe (rd_strobe)
    );

    // copy FSM; every bus output is registered, and the first read gets one setup cycle after CHECK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
            cur_src      <= '0;
            cur_dst      <= '0;
            remaining    <= '0;
`ifdef COPY_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cur_src   <= src_addr;
                    cur_dst   <= dst_addr;
                    remaining <= len;
                    busy      <= 1'b1;
                    state     <= CHECK;
`ifdef COPY_CHECKSUM_EN
                    checksum  <= '0;
`endif
                end
                CHECK: if (remaining == '0) state <= FIN;
                else if (bad_req) begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else state <= RD;
                RD: if (!m_read) begin
                    m_read    <= 1'b1;
                    m_address <= cur_src;
                end else if (!m_waitrequest) begin
                    m_read <= 1'b0;
                    state  <= RD_WAIT;
                end
                RD_WAIT: if (rd_strobe) begin
                    m_write      <= 1'b1;
                    m_address    <= cur_dst;
                    m_writedata  <= m_readdata;
                    m_byteenable <= '1;
                    state        <= WR;
                end
                WR: if (!m_waitrequest) begin
                    m_write      <= 1'b0;
                    m_byteenable <= '0;
                    cur_src      <= cur_src + 1'b1;
                    cur_dst      <= cur_dst + 1'b1;
                    remaining    <= remaining - 1'b1;
`ifdef COPY_CHECKSUM_EN
                    checksum     <= checksum + m_writedata;
`endif
                    if (remaining == ADDR_W'(1)) state <= FIN;
                    else begin
                        m_read    <= 1'b1;
                        m_address <= cur_src + 1'b1;
                        state     <= RD;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// tb_onchip_mem_copy_master: randomized self-checking bench with an array memory slave and copy reference model
module tb_onchip_mem_copy_master;
    localparam int DEPTH = 5120;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] src_addr = '0, dst_addr = '0, len = '0;
    logic        busy, done, error, m_chipselect, m_read, m_write;
    logic [12:0] m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;
`ifdef COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    int checks = 0, errors = 0;
    int r_busy, r_done, r_err, r_rd, r_wr, r_fin, r_both;
    bit r_stable;

    onchip_mem_copy_master #(.DEPTH(DEPTH), .READ_LATENCY(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest)
`ifdef COPY_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    // on-chip memory slave: one-cycle read latency, writes land on the accepting edge
    always @(posedge clk) begin
        if (m_read && !m_waitrequest) m_readdata <= mem[m_address];
        if (m_write && !m_waitrequest && m_byteenable == 4'hF) mem[m_address] = m_writedata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // reference model: forward word-by-word copy
    task automatic model_copy(input int s, input int d, input int l);
        for (int i = 0; i < l; i++) ref_mem[d+i] = ref_mem[s+i];
    endtask

    function automatic bit model_bad(input int s, input int d, input int l);
        return l != 0 && (s + l > DEPTH || d + l > DEPTH || (d > s && d < s + l));
    endfunction

    // runs one request; stall_rd>0 holds waitrequest 3 cycles on that read; restart_at>0 pulses start mid-copy
    task automatic run_copy(input logic [12:0] s, input logic [12:0] d, input logic [12:0] l,
                            input int stall_rd, input int restart_at);
        logic [12:0] held = '0;
        bit holding = 0;
        int stall_left = 3;
        r_busy = 0; r_done = 0; r_err = 0; r_rd = 0; r_wr = 0; r_fin = 0; r_both = 0; r_stable = 1;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 500; c++) begin
            if (done) r_done++;
            if (error) r_err++;
            if (m_read && m_write) r_both++;
            if (!busy) begin
                r_fin = c;
                break;
            end
            r_busy++;
            start = (c == restart_at);
            if (c == restart_at) begin
                src_addr = 13'd0; dst_addr = 13'd4000; len = 13'd1;
            end
            m_waitrequest = 1'b0;
            if (stall_rd > 0 && r_rd == stall_rd - 1) begin
                if (m_read && !holding) begin
                    held = m_address;
                    holding = 1;
                end else if (holding && (!m_read || m_address !== held)) r_stable = 0;
                if (m_read && stall_left > 0) begin
                    m_waitrequest = 1'b1;
                    stall_left--;
                end
            end
            if (m_read && !m_waitrequest) r_rd++;
            if (m_write && !m_waitrequest) r_wr++;
            @(negedge clk);
        end
        start = 1'b0;
        m_waitrequest = 1'b0;
        @(negedge clk);
        if (done) r_done++;
        if (error) r_err++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, error, m_read, m_write, m_chipselect, m_address, m_byteenable, m_writedata} !== '0) begin
            errors++;
            $display("FAIL reset_values got busy=%b addr=%h be=%h wd=%h want all zero", busy, m_address, m_byteenable, m_writedata);
        end
`ifdef COPY_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h0) begin
            errors++;
            $display("FAIL reset_checksum got %h want 0", checksum);
        end
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        run_copy(13'd0, 13'd100, 13'd4, 0, 0);
        checks++;
        if (r_busy !== 15 || r_fin == 0) begin
            errors++;
            $display("FAIL basic_busy got %0d cycles (fin %0d) want 15", r_busy, r_fin);
        end
        checks++;
        if (r_done !== 1 || r_err !== 0) begin
            errors++;
            $display("FAIL basic_pulses got done=%0d error=%0d want 1/0", r_done, r_err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[100+i] !== 32'(('h11) * (i + 1))) begin
                errors++;
                $display("FAIL basic_word%0d got %h want %h", i, mem[100+i], 32'(('h11) * (i + 1)));
            end
        end
        checks++;
        if (r_rd !== 4 || r_wr !== 4 || r_both !== 0) begin
            errors++;
            $display("FAIL basic_bus got rd=%0d wr=%0d both=%0d want 4/4/0", r_rd, r_wr, r_both);
        end
    endtask

    task automatic test_len_zero();
        run_copy(13'd7, 13'd900, 13'd0, 0, 0);
        checks++;
        if (r_busy !== 2 || r_done !== 1 || r_err !== 0) begin
            errors++;
            $display("FAIL len0 got busy=%0d done=%0d error=%0d want 2/1/0", r_busy, r_done, r_err);
        end
        checks++;
        if (r_rd + r_wr !== 0) begin
            errors++;
            $display("FAIL len0_bus got %0d transfers want 0", r_rd + r_wr);
        end
    endtask

    task automatic test_errors();
        logic [12:0] es [2] = '{13'd5118, 13'd10};
        logic [12:0] ed [2] = '{13'd0, 13'd12};
        logic [12:0] el [2] = '{13'd4, 13'd8};
        for (int k = 0; k < 2; k++) begin
            run_copy(es[k], ed[k], el[k], 0, 0);
            checks++;
            if (r_err !== 1 || r_done !== 0 || r_busy !== 1) begin
                errors++;
                $display("FAIL error%0d got error=%0d done=%0d busy=%0d want 1/0/1", k, r_err, r_done, r_busy);
            end
            checks++;
            if (r_rd + r_wr !== 0) begin
                errors++;
                $display("FAIL error%0d_bus got %0d transfers want 0", k, r_rd + r_wr);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) mem[20+i] = 32'hA000_0000 + 32'(i);
        run_copy(13'd20, 13'd200, 13'd4, 2, 0);
        checks++;
        if (r_busy !== 18 || r_done !== 1) begin
            errors++;
            $display("FAIL stall_busy got %0d done=%0d want 18/1", r_busy, r_done);
        end
        checks++;
        if (!r_stable) begin
            errors++;
            $display("FAIL stall_hold got unstable m_read/m_address want stable");
        end
        checks++;
        if (mem[201] !== 32'hA000_0001 || mem[203] !== 32'hA000_0003) begin
            errors++;
            $display("FAIL stall_data got %h %h want a0000001 a0000003", mem[201], mem[203]);
        end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        bit hit = 0;
        @(negedge clk);
        start = 1'b1; src_addr = 13'd0; dst_addr = 13'd300; len = 13'd8;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (m_write) w++;
            if (w == 2 && m_read) hit = 1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach got writes=%0d want third read issued", w);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, m_read, m_write, m_chipselect, m_address, m_byteenable, m_writedata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got busy=%b rd=%b addr=%h want all zero", busy, m_read, m_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) mem[40+i] = 32'hC0DE_0000 ^ 32'(i * 7);
        run_copy(13'd40, 13'd400, 13'd4, 0, 0);
        checks++;
        if (r_busy !== 15 || r_done !== 1 || mem[402] !== (32'hC0DE_0000 ^ 32'd14)) begin
            errors++;
            $display("FAIL reset_mid_recover got busy=%0d done=%0d w2=%h want 15/1/%h", r_busy, r_done, mem[402], 32'hC0DE_0000 ^ 32'd14);
        end
    endtask

    task automatic test_random();
        int bad_words;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int t = 0; t < 24; t++) begin
            int s = $urandom_range(0, DEPTH - 1);
            int d = $urandom_range(0, DEPTH - 1);
            int l = $urandom_range(0, 8);
            bit bad;
            if (t % 6 == 5) d = s + $urandom_range(1, 3);
            if (t % 8 == 7) s = DEPTH - $urandom_range(1, 4);
            if (d > DEPTH - 1) d = DEPTH - 1;
            bad = model_bad(s, d, l);
            ref_mem = mem;
            if (!bad) model_copy(s, d, l);
            run_copy(13'(s), 13'(d), 13'(l), 0, 0);
            checks++;
            if (bad ? (r_err !== 1 || r_done !== 0 || r_busy !== 1 || r_rd + r_wr !== 0)
                    : (r_err !== 0 || r_done !== 1 || r_busy !== (l == 0 ? 2 : 3 + 3 * l))) begin
                errors++;
                $display("FAIL rand%0d_ctrl s=%0d d=%0d l=%0d got busy=%0d done=%0d err=%0d rw=%0d want bad=%0d busy=%0d",
                         t, s, d, l, r_busy, r_done, r_err, r_rd + r_wr, bad, bad ? 1 : (l == 0 ? 2 : 3 + 3 * l));
            end
            bad_words = 0;
            for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad_words++;
            checks++;
            if (bad_words != 0 || r_both != 0) begin
                errors++;
                $display("FAIL rand%0d_data got %0d wrong words, %0d rd+wr overlaps want 0", t, bad_words, r_both);
            end
        end
    endtask

`ifdef COPY_CHECKSUM_EN
    task automatic test_checksum();
        mem[500] = 32'h1; mem[501] = 32'hFFFF_FFFF; mem[502] = 32'h5;
        run_copy(13'd500, 13'd600, 13'd3, 0, 0);
        checks++;
        if (checksum !== 32'h5 || r_done !== 1) begin
            errors++;
            $display("FAIL checksum got %h done=%0d want 00000005/1", checksum, r_done);
        end
        mem[4000] = 32'hDEAD_BEEF;
        run_copy(13'd500, 13'd700, 13'd3, 0, 3);
        checks++;
        if (checksum !== 32'h5 || r_busy !== 12 || r_done !== 1 || mem[4000] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL checksum_ignore got sum=%h busy=%0d done=%0d m4000=%h want 5/12/1/deadbeef",
                     checksum, r_busy, r_done, mem[4000]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_errors();
        test_stall();
        test_reset_mid();
`ifdef COPY_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
